// File: rtl/rdata_packetizer_if.sv
// AXI-Stream output bundle of the read-data packetizer.
//   tdata  : beat payload
//   tkeep  : byte enables (all ones on valid beats)
//   tlast  : packet end marker
//   tvalid : beat valid
//   tready : downstream ready
// master drives the stream, slave consumes it.
interface rdata_packetizer_if #(
  parameter int DATA_WIDTH = 512
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/rdata_packetizer.sv
// Turns the unstallable DDR4 read-return beat stream into AXI-Stream packets.
// Tracks outstanding reads, closes a packet when the last outstanding read
// returns or MAX_PKT_BEATS beats have been collected, and buffers beats in a
// small FIFO so the downstream can apply back-pressure.
//   clk, rst    : UI clock, synchronous active-high reset
//   ddr_read    : per-slot read-command strobes (0..4 reads per cycle)
//   rd_data     : returned read beat, qualified by rd_data_en
//   m_axis      : AXI-Stream master (tdata/tkeep/tlast/tvalid, tready)
//   outstanding : reads issued but not yet returned
//   drop_err    : sticky, a beat was lost on a full buffer
//   cnt_err     : sticky, outstanding counter underflow or saturation
module rdata_packetizer #(
  parameter int DATA_WIDTH    = 512,
  parameter int CNT_WIDTH     = 16,
  parameter int MAX_PKT_BEATS = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            ddr_read,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_en,
  rdata_packetizer_if.master    m_axis,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  drop_err,
  output logic                  cnt_err
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int FCW  = PW + 1;
  localparam int SW   = CNT_WIDTH + 3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  drop_err_q, drop_err_d;
  logic                  cnt_err_q, cnt_err_d;

  logic [2:0]            cur_reads;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         nxt;
  logic                  full, empty, pop, push, beat_last;

  always_comb begin
    cur_reads = {2'b0, ddr_read[0]} + {2'b0, ddr_read[1]}
              + {2'b0, ddr_read[2]} + {2'b0, ddr_read[3]};
    sum   = SW'(outstanding_q) + SW'(cur_reads);
    nxt   = sum - SW'(rd_data_en);
    full  = (count_q == FCW'(FIFO_DEPTH));
    empty = (count_q == '0);
    pop   = !empty && m_axis.tready;
    push  = rd_data_en && (!full || pop);
    // sum == 0 is the underflow case; that beat also ends the packet since
    // nothing is left outstanding once the counter clamps at zero.
    beat_last = (sum <= SW'(1)) || (beat_cnt_q == 8'(MAX_PKT_BEATS - 1));

    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + FCW'(push) - FCW'(pop);
    beat_cnt_d    = beat_cnt_q;
    drop_err_d    = drop_err_q;
    cnt_err_d     = cnt_err_q;
    outstanding_d = nxt[CNT_WIDTH-1:0];

    if (rd_data_en) begin
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + 8'd1;
      if (!push) drop_err_d = 1'b1;
    end

    if (rd_data_en && (sum == '0)) begin
      outstanding_d = '0;
      cnt_err_d     = 1'b1;
    end else if (nxt > SW'({CNT_WIDTH{1'b1}})) begin
      outstanding_d = '1;
      cnt_err_d     = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = '{data: rd_data, last: beat_last};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      drop_err_q    <= 1'b0;
      cnt_err_q     <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
      drop_err_q    <= drop_err_d;
      cnt_err_q     <= cnt_err_d;
    end
  end

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = mem_q[rd_ptr_q].data;
  assign m_axis.tlast  = mem_q[rd_ptr_q].last;
  assign m_axis.tkeep  = '1;
  assign outstanding   = outstanding_q;
  assign drop_err      = drop_err_q;
  assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_rdata_packetizer.sv
// Self-checking bench for rdata_packetizer: a directed vector table, hand
// sequences for packet splitting, drops and saturation, then randomized
// traffic against a queue-based reference model.
module tb_rdata_packetizer;
  localparam int DW    = 32;
  localparam int CW    = 5;
  localparam int MAXB  = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [3:0]    ddr_read;
  logic [DW-1:0] rd_data;
  logic          rd_data_en;
  logic [CW-1:0] outstanding;
  logic          drop_err, cnt_err;

  rdata_packetizer_if #(.DATA_WIDTH(DW)) axis ();

  rdata_packetizer #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_PKT_BEATS(MAXB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ddr_read(ddr_read), .rd_data(rd_data),
    .rd_data_en(rd_data_en), .m_axis(axis), .outstanding(outstanding),
    .drop_err(drop_err), .cnt_err(cnt_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers and a queue of pending beats.
  typedef struct { logic [DW-1:0] data; bit last; } beat_t;
  beat_t m_q[$];
  int    m_outs, m_bc;
  bit    m_drop, m_cerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] rd, input bit en,
                            input logic [DW-1:0] d, input bit rdy);
    int sum, nxt;
    bit pop, accept, last;
    if (r) begin
      m_q.delete(); m_outs = 0; m_bc = 0; m_drop = 0; m_cerr = 0;
      return;
    end
    sum = m_outs + $countones(rd);
    pop = (m_q.size() > 0) && rdy;
    accept = 0; last = 0;
    if (en) begin
      last = (sum <= 1) || (m_bc == MAXB - 1);
      m_bc = last ? 0 : m_bc + 1;
      accept = (m_q.size() < DEPTH) || pop;
      if (!accept) m_drop = 1;
    end
    nxt = sum - int'(en);
    if (en && sum == 0) begin
      nxt = 0; m_cerr = 1;
    end else if (nxt > (2**CW) - 1) begin
      nxt = (2**CW) - 1; m_cerr = 1;
    end
    m_outs = nxt;
    if (pop) void'(m_q.pop_front());
    if (accept) m_q.push_back('{d, last});
  endtask

  task automatic check_model();
    chk("mdl_tvalid", axis.tvalid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("mdl_tdata", axis.tdata, m_q[0].data);
      chk("mdl_tlast", axis.tlast, m_q[0].last);
      chk("mdl_tkeep", axis.tkeep, {(DW/8){1'b1}});
    end
    chk("mdl_outstanding", outstanding, m_outs);
    chk("mdl_drop_err", drop_err, m_drop);
    chk("mdl_cnt_err", cnt_err, m_cerr);
  endtask

  task automatic step(input bit r, input logic [3:0] rd, input bit en,
                      input logic [DW-1:0] d, input bit rdy);
    rst = r; ddr_read = rd; rd_data_en = en; rd_data = d; axis.tready = rdy;
    model_step(r, rd, en, d, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst; bit [3:0] rd; bit en; bit [31:0] data; bit rdy;
    bit e_valid; bit e_last; bit [31:0] e_data; int e_outs; bit e_drop; bit e_cerr;
  } vec_t;
  vec_t tbl[17];

  initial begin
    int lasts, drained;
    rst = 1'b1; ddr_read = '0; rd_data = '0; rd_data_en = 1'b0; axis.tready = 1'b0;

    //          rst   rd    en    data          rdy  | valid last  e_data        outs drop  cerr
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 32'hA1,       1'b1, 1'b1, 1'b1, 32'hA1,       0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        4, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 1'b1, 32'hB0,       1'b1, 1'b1, 1'b0, 32'hB0,       3, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 32'hB1,       1'b1, 1'b1, 1'b0, 32'hB1,       2, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 32'hB2,       1'b1, 1'b1, 1'b0, 32'hB2,       1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 32'hB3,       1'b1, 1'b1, 1'b1, 32'hB3,       0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 32'hC0,       1'b1, 1'b1, 1'b1, 32'hC0,       0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 4'hF, 1'b1, 32'h99,       1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        4, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 32'hD0,       1'b0, 1'b1, 1'b0, 32'hD0,       3, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 1'b1, 32'hD1,       1'b0, 1'b1, 1'b0, 32'hD0,       2, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'hF, 1'b1, 32'hD2,       1'b0, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].rd, tbl[i].en, tbl[i].data, tbl[i].rdy);
      chk($sformatf("v%0d_tvalid", i), axis.tvalid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_tlast", i), axis.tlast, tbl[i].e_last);
        chk($sformatf("v%0d_tdata", i), axis.tdata, tbl[i].e_data);
      end
      chk($sformatf("v%0d_outstanding", i), outstanding, tbl[i].e_outs);
      chk($sformatf("v%0d_drop_err", i), drop_err, tbl[i].e_drop);
      chk($sformatf("v%0d_cnt_err", i), cnt_err, tbl[i].e_cerr);
    end

    // 20 reads split into a 16-beat packet and a 4-beat packet.
    for (int i = 0; i < 5; i++) step(1'b0, 4'hF, 1'b0, '0, 1'b1);
    chk("pkt20_outstanding", outstanding, 20);
    lasts = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 4'h0, 1'b1, DW'(k), 1'b1);
      chk($sformatf("pkt20_tdata_%0d", k), axis.tdata, k);
      chk($sformatf("pkt20_tlast_%0d", k), axis.tlast, (k == 16) || (k == 20));
      if (axis.tlast) lasts++;
    end
    chk("pkt20_last_count", lasts, 2);
    step(1'b0, 4'h0, 1'b0, '0, 1'b1);
    chk("pkt20_drained", axis.tvalid, 0);

    // Back-pressure: five beats into a four-entry buffer, fifth is dropped.
    step(1'b0, 4'hF, 1'b0, '0, 1'b0);
    step(1'b0, 4'h1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'h0, 1'b1, DW'(32'hF0 + k), 1'b0);
      chk($sformatf("drop_flag_%0d", k), drop_err, k == 4);
    end
    chk("drop_outstanding", outstanding, 0);
    drained = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drop_head_valid_%0d", k), axis.tvalid, 1);
      chk($sformatf("drop_head_data_%0d", k), axis.tdata, 32'hF0 + k);
      if (axis.tvalid) drained++;
      step(1'b0, 4'h0, 1'b0, '0, 1'b1);
    end
    chk("drop_drained_count", drained, 4);
    chk("drop_empty_after", axis.tvalid, 0);
    chk("drop_sticky", drop_err, 1);

    // Outstanding counter saturation at 2^CW-1.
    step(1'b1, 4'h0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 4'hF, 1'b0, '0, 1'b1);
    chk("sat_pre_value", outstanding, 28);
    chk("sat_pre_err", cnt_err, 0);
    step(1'b0, 4'hF, 1'b0, '0, 1'b1);
    chk("sat_value", outstanding, 31);
    chk("sat_err", cnt_err, 1);
    step(1'b0, 4'h1, 1'b0, '0, 1'b1);
    chk("sat_hold", outstanding, 31);

    // Randomized traffic against the model.
    step(1'b1, 4'h0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rd;
      bit en, rdy, r;
      rd  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      en  = ($urandom_range(0, 2) != 0);
      rdy = (i >= 1000 && i < 1300) ? ($urandom_range(0, 7) == 0)
                                    : ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 249) == 0);
      step(r, rd, en, DW'($urandom), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rdata_packetizer.md
RDATA_PACKETIZER -- requirements
Module: rdata_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 512, SHALL set the read-data beat width in bits.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of the outstanding-read counter.
REQ-003 Parameter MAX_PKT_BEATS, default 16, SHALL set the maximum number of beats per output packet (range 1..255).
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set the internal beat-buffer depth (power of two, at least 2).
REQ-005 clk  input  1  SHALL be the DDR4 UI clock; the block has one clock.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 ddr_read  input  4  SHALL carry per-slot read-command strobes issued this cycle (0..4 reads per cycle).
REQ-008 rd_data  input  DATA_WIDTH  SHALL carry the returned read beat from the DDR4 interface.
REQ-009 rd_data_en  input  1  SHALL qualify rd_data and cannot be stalled.
REQ-010 m_axis_tdata  output  DATA_WIDTH  SHALL carry the AXI-Stream beat.
REQ-011 m_axis_tkeep  output  DATA_WIDTH/8  SHALL be all ones whenever m_axis_tvalid is high.
REQ-012 m_axis_tlast  output  1  SHALL mark the packet end.
REQ-013 m_axis_tvalid  output  1  SHALL mark a valid beat.
REQ-014 m_axis_tready  input  1  SHALL be the downstream ready signal.
REQ-015 outstanding  output  CNT_WIDTH  SHALL report the reads issued but not yet returned.
REQ-016 drop_err  output  1  SHALL be a sticky flag set when a beat is lost because the buffer is full.
REQ-017 cnt_err  output  1  SHALL be a sticky flag set on counter underflow or saturation.

Function
REQ-018 Each cycle, the block SHALL compute cur_reads as the popcount of ddr_read (0..4).
REQ-019 Counter next value: outstanding SHALL be updated to outstanding + cur_reads - rd_data_en, evaluated in CNT_WIDTH+3 bits.
REQ-020 Underflow: if outstanding + cur_reads == 0 while rd_data_en is high, outstanding SHALL stay 0, the beat SHALL still be handled, and cnt_err SHALL be set.
REQ-021 Saturation: if the next value exceeds 2^CNT_WIDTH-1, outstanding SHALL saturate at all ones and cnt_err SHALL be set.
REQ-022 Beat counter: beat_cnt (8 bits) SHALL count the beats buffered in the current packet.
REQ-023 Last-beat rule: a beat SHALL be tagged last when outstanding + cur_reads - 1 == 0 or beat_cnt == MAX_PKT_BEATS-1.
REQ-024 Beat-counter update: beat_cnt SHALL clear to 0 after a last-tagged beat and increment otherwise.
REQ-025 Buffering: each beat with rd_data_en high SHALL be written into a FIFO_DEPTH-entry FIFO holding {data, last}, in order.
REQ-026 Push when full: a push SHALL be accepted when the FIFO is not full, or when it is full and a pop (m_axis_tvalid && m_axis_tready) occurs in the same cycle.
REQ-027 Dropped beat: a beat that cannot be accepted SHALL be discarded and drop_err SHALL be set.
REQ-028 Dropped-beat accounting: a dropped beat SHALL still decrement outstanding and SHALL still apply the beat_cnt rules of REQ-023/REQ-024.
REQ-029 Output: m_axis_tvalid SHALL equal FIFO not-empty, and tdata/tlast SHALL present the FIFO head.
REQ-030 Latency: a beat SHALL appear on m_axis_tvalid one cycle after its rd_data_en cycle when the FIFO was empty.
REQ-031 Stability: while m_axis_tvalid is high and m_axis_tready is low, tdata, tlast and tvalid SHALL remain stable.
REQ-032 Pop: a beat SHALL be removed from the FIFO only in a cycle where m_axis_tvalid && m_axis_tready.
REQ-033 Empty FIFO: a pop SHALL never occur while the FIFO is empty, and the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 Output path: no output SHALL depend combinationally on rd_data or rd_data_en; m_axis_tvalid SHALL depend only on registered FIFO state.

Reset
REQ-035 While rst is high at a clk edge, the block SHALL clear outstanding, beat_cnt, the FIFO pointers and count, drop_err and cnt_err to 0, and m_axis_tvalid SHALL be 0 the following cycle.
REQ-036 A reset asserted mid-packet SHALL discard all buffered beats without emitting tlast.
REQ-037 Inputs present during the reset cycle SHALL be ignored.

Verification
REQ-038 Issue ddr_read=4'b0001, then one rd_data_en beat with m_axis_tready=1 -> one beat is output with tlast=1 one cycle later, and outstanding returns to 0.
REQ-039 Issue ddr_read=4'b1111 in one cycle, then 4 beats -> 4 beats are output with tlast only on the 4th, and outstanding reads 4,3,2,1,0.
REQ-040 Issue 20 reads with MAX_PKT_BEATS=16 and return 20 beats -> tlast is on beat 16 and beat 20.
REQ-041 Hold m_axis_tready=0 and return 5 beats with FIFO_DEPTH=4 -> 4 beats are buffered, the 5th is dropped, drop_err=1, and outstanding still reaches 0.
REQ-042 Pulse rd_data_en with outstanding=0 -> cnt_err=1, outstanding stays 0, and the beat is output with tlast=1.
REQ-043 Assert rst after 2 of 4 beats are buffered -> tvalid=0 on the next cycle, and outstanding, drop_err and cnt_err all read 0.
